net_egr_arbiter: RTL and testbench
==================================

# net_egr_arbiter

Packet-granular round-robin arbiter that shares the physical network egress port among NUM_PORTS per-region egress AXI streams. Each input is fed by that region's protocol handler, which guarantees every packet terminates with tlast. The arbiter grants one source for a whole packet, stamps tid with the source index and drives a registered output toward the MAC. Per-port decouple inputs block new grants to isolated regions.

## Interface
- NUM_PORTS, 4, number of egress sources (2..16)
- AXIS_BUS_WIDTH, 64, tdata width in bits
- AXIS_ID_WIDTH, 4, output tid width; must be >= clog2(NUM_PORTS)
- AXIS_DEST_WIDTH, 4, tdest width, passed through unchanged
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  NUM_PORTS*AXIS_BUS_WIDTH  packed per-port data, port i at slice i
- s_axis_tdest  in  NUM_PORTS*AXIS_DEST_WIDTH  packed per-port dest
- s_axis_tkeep  in  NUM_PORTS*AXIS_BUS_WIDTH/8  packed per-port keep
- s_axis_tlast  in  NUM_PORTS  per-port last
- s_axis_tvalid  in  NUM_PORTS  per-port valid
- s_axis_tready  out  NUM_PORTS  per-port ready; only the granted bit can be 1
- m_axis_tdata/tdest/tkeep  out  AXIS_BUS_WIDTH/AXIS_DEST_WIDTH/AXIS_BUS_WIDTH/8  registered output beat
- m_axis_tid  out  AXIS_ID_WIDTH  index of source port, zero-extended
- m_axis_tlast, m_axis_tvalid  out  1 each  registered output
- m_axis_tready  in  1  downstream ready
- decouple  in  NUM_PORTS  1 = port excluded from new grants
- grant_busy  out  1  a packet is currently granted
- grant_port  out  clog2(NUM_PORTS)  currently or last granted port

## Operation
- FSM with two states: ARB and XFER.
- ARB: the eligible set is req = s_axis_tvalid & ~decouple. If req is non-zero, the arbiter picks the first set bit searching from rr_ptr upward, wrapping modulo NUM_PORTS. It registers grant_port, sets grant_busy and moves to XFER. All s_axis_tready are 0 while in ARB.
- XFER: s_axis_tready[grant_port] = m_axis_tready || !m_axis_tvalid. All other ready bits are 0.
- On an accepted beat (valid & ready on the granted port), the output register loads tdata, tdest, tkeep, tlast and tid = grant_port, and m_axis_tvalid is set to 1.
- When there is no accept and m_axis_tready=1, m_axis_tvalid is cleared to 0.
- When the accepted beat has tlast=1: go to ARB, clear grant_busy, and set rr_ptr = (grant_port+1) mod NUM_PORTS.
- Decouple asserted mid-packet does not abort the packet; the granted port finishes to tlast. Decouple only blocks future grants.
- A tvalid drop mid-packet on the granted port simply stalls the arbiter. No timeout is applied here; upstream handlers enforce packet integrity.

## Timing
- Reset values: m_axis_tvalid=0, s_axis_tready=0, grant_busy=0, grant_port=0, rr_ptr=0, state=ARB. Data registers are not reset.
- Asserting areset mid-packet clears all of these immediately. The partial packet is dropped; downstream sees tvalid fall without tlast.
- Latency: a request seen in ARB at cycle n produces grant at n+1, the first accept at n+1, and m_axis_tvalid at n+2.
- There is one ARB bubble cycle between packets, so sustained throughput is L/(L+1) for packets of L beats.
- The output register follows the standard AXI-S rule: tdata/tid/tlast are held stable while tvalid=1 and tready=0.
- Simultaneous requests are resolved purely by rr_ptr; no port can be granted twice in a row while another eligible port is requesting.
- A single-beat packet (tlast on the first beat) returns to ARB on the next cycle.

## Structure
- Package net_arb_pkg holds:
  - the state encoding (ARB, XFER);
  - the function clog2_min1 for index widths;
  - the elaboration check that AXIS_ID_WIDTH >= clog2(NUM_PORTS).
- Sub-module rr_prio_select: combinational rotating priority encoder. Inputs are req[N] and ptr; outputs are a one-hot grant, the grant index and any_req.

## Test plan
- Port 2 only, 3-beat packet, m_axis_tready=1: grant at n+1, three output beats with tid=2 and tlast on the third beat, grant_busy falls after the tlast accept.
- Ports 0 and 1 both sending continuous 2-beat packets: output tid sequence is 0,1,0,1; each packet boundary is followed by exactly one idle cycle.
- NUM_PORTS=4, all requesting, rr_ptr=3: grant order is 3,0,1,2, checking wrap-around.
- m_axis_tready toggled 1,0,0,1 mid-packet: the output beat stays stable while stalled, and no beats are lost or duplicated.
- decouple[1]=1 with ports 1 and 3 requesting: only port 3 is granted. Asserting decouple[3] mid-packet still lets port 3's packet complete to tlast.
- areset pulsed during beat 2 of a 4-beat packet: m_axis_tvalid, s_axis_tready and grant_busy go to 0 immediately; after release, a fresh packet from port 0 is granted.

Source files
------------

// File: rtl/net_arb_pkg.sv
// Shared definitions for the network egress arbiter: FSM encoding, index-width
// helper and the parameter sanity check used at elaboration.
package net_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int num_ports, input int id_width);
        return (num_ports >= 2) && (num_ports <= 16) &&
               (id_width >= clog2_min1(num_ports));
    endfunction

endpackage

// File: rtl/net_egr_arbiter_rr_prio_select.sv
// Rotating priority encoder: first set bit of req at or above ptr, wrapping
// modulo N. Purely combinational.
module rr_prio_select
    import net_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        any_req  = |req;
        cand     = 0;
        cand_idx = '0;
        // Walk from farthest to nearest so the nearest requester wins last.
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/net_egr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream egress among
// NUM_PORTS sources; stamps tid with the source index, registered output.
module net_egr_arbiter
    import net_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_DEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [NUM_PORTS*AXIS_BUS_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                     s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                     s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                     s_axis_tready,
    output logic [AXIS_BUS_WIDTH-1:0]                m_axis_tdata,
    output logic [AXIS_DEST_WIDTH-1:0]               m_axis_tdest,
    output logic [AXIS_BUS_WIDTH/8-1:0]              m_axis_tkeep,
    output logic [AXIS_ID_WIDTH-1:0]                 m_axis_tid,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    input  logic [NUM_PORTS-1:0]                     decouple,
    output logic                                     grant_busy,
    output logic [clog2_min1(NUM_PORTS)-1:0]         grant_port
);

    localparam int PW = clog2_min1(NUM_PORTS);
    localparam int KW = AXIS_BUS_WIDTH / 8;

    if (!params_ok(NUM_PORTS, AXIS_ID_WIDTH)) begin : g_bad_params
        $error("net_egr_arbiter: NUM_PORTS=%0d / AXIS_ID_WIDTH=%0d unsupported",
               NUM_PORTS, AXIS_ID_WIDTH);
    end

    arb_state_e                state, state_next;
    logic [PW-1:0]             rr_ptr;
    logic [NUM_PORTS-1:0]      grant_oh;
    logic [NUM_PORTS-1:0]      sel_grant;
    logic [PW-1:0]             sel_idx;
    logic                      any_req;
    logic                      accept;
    logic [AXIS_BUS_WIDTH-1:0] sel_data;
    logic [AXIS_DEST_WIDTH-1:0] sel_dest;
    logic [KW-1:0]             sel_keep;
    logic                      sel_last;
    logic [PW-1:0]             next_ptr;

    rr_prio_select #(
        .N  (NUM_PORTS),
        .IW (PW)
    ) u_sel (
        .req     (s_axis_tvalid & ~decouple),
        .ptr     (rr_ptr),
        .grant   (sel_grant),
        .idx     (sel_idx),
        .any_req (any_req)
    );

    // Only the granted source may see ready, and only when the output slot
    // is free or draining this cycle.
    assign s_axis_tready = (state == XFER && (m_axis_tready || !m_axis_tvalid))
                           ? grant_oh : '0;
    assign accept   = |(s_axis_tvalid & s_axis_tready);
    assign next_ptr = (grant_port == PW'(NUM_PORTS - 1)) ? '0 : grant_port + 1'b1;

    always_comb begin
        sel_data = '0;
        sel_dest = '0;
        sel_keep = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_oh[i]) begin
                sel_data = sel_data | s_axis_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
                sel_dest = sel_dest | s_axis_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
                sel_keep = sel_keep | s_axis_tkeep[i*KW +: KW];
                sel_last = sel_last | s_axis_tlast[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     if (any_req) state_next = XFER;
            XFER:    if (accept && sel_last) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= ARB;
            grant_oh      <= '0;
            grant_port    <= '0;
            grant_busy    <= 1'b0;
            rr_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ARB && any_req) begin
                grant_oh   <= sel_grant;
                grant_port <= sel_idx;
                grant_busy <= 1'b1;
            end
            if (accept && sel_last) begin
                grant_busy <= 1'b0;
                rr_ptr     <= next_ptr;
            end
            if (accept)             m_axis_tvalid <= 1'b1;
            else if (m_axis_tready) m_axis_tvalid <= 1'b0;
        end
    end

    // NOTE: the payload registers carry no reset; m_axis_tvalid qualifies them,
    // so resetting wide data would only add reset fan-out.
    always_ff @(posedge aclk) begin
        if (accept) begin
            m_axis_tdata <= sel_data;
            m_axis_tdest <= sel_dest;
            m_axis_tkeep <= sel_keep;
            m_axis_tlast <= sel_last;
            m_axis_tid   <= AXIS_ID_WIDTH'(grant_port);
        end
    end

endmodule

// File: tb/tb_net_egr_arbiter.sv
// Self-checking bench for net_egr_arbiter: output scoreboard, a table of
// single-beat arbitration vectors and hand-written multi-cycle sequences.
module tb_net_egr_arbiter;

    localparam int NP  = 4;
    localparam int W   = 64;
    localparam int IDW = 4;
    localparam int DW  = 4;
    localparam int KW  = W / 8;

    logic               aclk = 1'b0;
    logic               areset;
    logic [NP*W-1:0]    s_axis_tdata;
    logic [NP*DW-1:0]   s_axis_tdest;
    logic [NP*KW-1:0]   s_axis_tkeep;
    logic [NP-1:0]      s_axis_tlast;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP-1:0]      s_axis_tready;
    logic [W-1:0]       m_axis_tdata;
    logic [DW-1:0]      m_axis_tdest;
    logic [KW-1:0]      m_axis_tkeep;
    logic [IDW-1:0]     m_axis_tid;
    logic               m_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [NP-1:0]      decouple;
    logic               grant_busy;
    logic [1:0]         grant_port;

    always #5 aclk = ~aclk;

    net_egr_arbiter #(
        .NUM_PORTS       (NP),
        .AXIS_BUS_WIDTH  (W),
        .AXIS_ID_WIDTH   (IDW),
        .AXIS_DEST_WIDTH (DW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .decouple      (decouple),
        .grant_busy    (grant_busy),
        .grant_port    (grant_port)
    );

    logic          src_valid [NP];
    logic          src_last  [NP];
    logic [W-1:0]  src_data  [NP];
    logic [DW-1:0] src_dest  [NP];
    logic [KW-1:0] src_keep  [NP];

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            s_axis_tvalid[i]          = src_valid[i];
            s_axis_tlast[i]           = src_last[i];
            s_axis_tdata[i*W +: W]    = src_data[i];
            s_axis_tdest[i*DW +: DW]  = src_dest[i];
            s_axis_tkeep[i*KW +: KW]  = src_keep[i];
        end
    end

    typedef struct packed {
        logic [IDW-1:0] tid;
        logic [W-1:0]   data;
        logic [DW-1:0]  dest;
        logic [KW-1:0]  keep;
        logic           last;
    } beat_t;

    typedef struct {
        logic [NP-1:0] valid;
        logic [NP-1:0] dec;
        logic          exp_grant;
        int            exp_port;
    } vec_t;

    beat_t sb[$];
    int    stamps[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [W-1:0] beat_data(input int port, input int tag, input int b);
        return {8'(tag), 24'h0, 8'(port), 16'h0, 8'(b)};
    endfunction

    function automatic logic [DW-1:0] beat_dest(input int port, input int b);
        return DW'(port + b + 1);
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int b);
        logic [KW-1:0] ones;
        ones = '1;
        return ones >> b;
    endfunction

    task automatic push_pkt(input int port, input int tag, input int len);
        for (int b = 0; b < len; b++)
            sb.push_back('{tid: IDW'(port), data: beat_data(port, tag, b),
                           dest: beat_dest(port, b), keep: beat_keep(b),
                           last: (b == len - 1)});
    endtask

    task automatic drive_beat(input int port, input int tag, input int b, input int len);
        src_valid[port] = 1'b1;
        src_data[port]  = beat_data(port, tag, b);
        src_dest[port]  = beat_dest(port, b);
        src_keep[port]  = beat_keep(b);
        src_last[port]  = (b == len - 1);
    endtask

    // Each beat is presented at a negedge and held until ready is seen.
    task automatic send_packet(input int port, input int tag, input int len);
        for (int b = 0; b < len; b++) begin
            int waited;
            @(negedge aclk);
            drive_beat(port, tag, b, len);
            waited = 0;
            #1;
            while (!s_axis_tready[port]) begin
                @(negedge aclk);
                #1;
                waited++;
                if (waited > 300) begin
                    bound_fail($sformatf("send_p%0d_tag%0h", port, tag));
                    return;
                end
            end
        end
    endtask

    task automatic stop_port(input int port);
        @(negedge aclk);
        src_valid[port] = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        #3;
        check(name, sb.size(), 0);
    endtask

    // Output monitor: scoreboard compare on handshake, hold check while stalled.
    initial begin
        beat_t exp_b;
        beat_t cur_b;
        beat_t prev_b;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev_b     = '0;
        forever begin
            @(negedge aclk);
            #2;
            cur_b = '{tid: m_axis_tid, data: m_axis_tdata, dest: m_axis_tdest,
                      keep: m_axis_tkeep, last: m_axis_tlast};
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", m_axis_tvalid, 1'b1);
                    check("stall_hold_beat", cur_b, prev_b);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    stamps.push_back(cyc);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL out_unexpected: got beat tid=%0d data=0x%0h expected none",
                                 m_axis_tid, m_axis_tdata);
                    end else begin
                        exp_b = sb.pop_front();
                        check("out_tid", cur_b.tid, exp_b.tid);
                        check("out_data", cur_b.data, exp_b.data);
                        check("out_dest_keep", {cur_b.dest, cur_b.keep}, {exp_b.dest, exp_b.keep});
                        check("out_last", cur_b.last, exp_b.last);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_b     = cur_b;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        int   base;

        // rr_ptr entering the table is 2 (port 1 was granted last).
        vecs[0]  = '{4'b0100, 4'b0000, 1'b1, 2};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 3};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 0};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 1};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 2};
        vecs[5]  = '{4'b1010, 4'b0010, 1'b1, 3};
        vecs[6]  = '{4'b1010, 4'b0000, 1'b1, 1};
        vecs[7]  = '{4'b0011, 4'b0000, 1'b1, 0};
        vecs[8]  = '{4'b0011, 4'b0000, 1'b1, 1};
        vecs[9]  = '{4'b1001, 4'b1001, 1'b0, 0};
        vecs[10] = '{4'b0001, 4'b1000, 1'b1, 0};
        vecs[11] = '{4'b1000, 4'b0000, 1'b1, 3};

        areset        = 1'b1;
        m_axis_tready = 1'b1;
        decouple      = '0;
        for (int i = 0; i < NP; i++) begin
            src_valid[i] = 1'b0;
            src_last[i]  = 1'b0;
            src_data[i]  = '0;
            src_dest[i]  = '0;
            src_keep[i]  = '0;
        end

        repeat (3) @(negedge aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tready", s_axis_tready, 4'b0000);
        check("rst_busy", grant_busy, 1'b0);
        check("rst_port", grant_port, 2'd0);
        @(negedge aclk);
        areset = 1'b0;

        // Single source, 3-beat packet: latency and grant_busy release.
        push_pkt(2, 'hA0, 3);
        fork
            begin
                send_packet(2, 'hA0, 3);
                stop_port(2);
            end
            begin
                @(negedge aclk);
                @(negedge aclk);
                #1;
                check("a_grant_busy", grant_busy, 1'b1);
                check("a_grant_port", grant_port, 2'd2);
                check("a_tvalid_not_yet", m_axis_tvalid, 1'b0);
                check("a_ready_onehot", s_axis_tready, 4'b0100);
                @(negedge aclk);
                #1;
                check("a_first_valid", m_axis_tvalid, 1'b1);
                check("a_first_tid", m_axis_tid, 4'd2);
                @(negedge aclk);
                @(negedge aclk);
                #1;
                check("a_busy_after_last", grant_busy, 1'b0);
                check("a_out_last", {m_axis_tvalid, m_axis_tlast}, 2'b11);
            end
        join
        wait_sb_empty("a_drain");

        // Ports 0 and 1 streaming 2-beat packets back to back.
        base = stamps.size();
        push_pkt(0, 'hB0, 2);
        push_pkt(1, 'hB1, 2);
        push_pkt(0, 'hB2, 2);
        push_pkt(1, 'hB3, 2);
        fork
            begin
                send_packet(0, 'hB0, 2);
                send_packet(0, 'hB2, 2);
                stop_port(0);
            end
            begin
                send_packet(1, 'hB1, 2);
                send_packet(1, 'hB3, 2);
                stop_port(1);
            end
        join
        wait_sb_empty("b_drain");
        check("b_beat_count", stamps.size() - base, 8);
        if (stamps.size() - base >= 8) begin
            for (int k = 0; k < 7; k++)
                check($sformatf("b_gap_%0d", k), stamps[base+k+1] - stamps[base+k],
                      (k % 2 == 0) ? 1 : 2);
        end

        // Table of single-beat arbitration decisions.
        for (int r = 0; r < 12; r++) begin
            @(negedge aclk);
            for (int p = 0; p < NP; p++)
                if (vecs[r].valid[p]) drive_beat(p, 'hC0 + r, 0, 1);
            decouple = vecs[r].dec;
            if (vecs[r].exp_grant) push_pkt(vecs[r].exp_port, 'hC0 + r, 1);
            @(negedge aclk);
            #1;
            check($sformatf("c%0d_busy", r), grant_busy, vecs[r].exp_grant);
            check($sformatf("c%0d_ready", r), s_axis_tready,
                  vecs[r].exp_grant ? (1 << vecs[r].exp_port) : 0);
            if (vecs[r].exp_grant)
                check($sformatf("c%0d_port", r), grant_port, vecs[r].exp_port);
            @(negedge aclk);
            for (int p = 0; p < NP; p++) src_valid[p] = 1'b0;
            decouple = '0;
        end
        wait_sb_empty("c_drain");

        // Downstream stall 1,0,0,1 in the middle of a 4-beat packet.
        base = stamps.size();
        push_pkt(2, 'hD0, 4);
        fork
            begin
                send_packet(2, 'hD0, 4);
                stop_port(2);
            end
            begin
                int n;
                n = 0;
                @(negedge aclk);
                #1;
                while (!m_axis_tvalid && n < 20) begin
                    @(negedge aclk);
                    #1;
                    n++;
                end
                if (n >= 20) bound_fail("d_first_beat");
                @(negedge aclk) m_axis_tready = 1'b0;
                @(negedge aclk) m_axis_tready = 1'b0;
                @(negedge aclk) m_axis_tready = 1'b1;
            end
        join
        wait_sb_empty("d_drain");
        check("d_beat_count", stamps.size() - base, 4);

        // Decouple blocks port 1; decoupling port 3 mid-packet lets it finish.
        @(negedge aclk) decouple = 4'b0010;
        push_pkt(3, 'hE3, 3);
        push_pkt(1, 'hE1, 3);
        fork
            begin
                send_packet(3, 'hE3, 3);
                stop_port(3);
            end
            begin
                send_packet(1, 'hE1, 3);
                stop_port(1);
            end
            begin
                int n;
                bit seen;
                n    = 0;
                seen = 1'b0;
                while (n < 20 && !seen) begin
                    @(negedge aclk);
                    #1;
                    n++;
                    if (grant_busy) seen = 1'b1;
                end
                check("e_first_grant_port", {seen, grant_port}, {1'b1, 2'd3});
                @(negedge aclk) decouple = 4'b1010;
                n = 0;
                #1;
                while (grant_busy && n < 20) begin
                    @(negedge aclk);
                    #1;
                    n++;
                end
                check("e_port3_done", grant_busy, 1'b0);
                repeat (4) begin
                    @(negedge aclk);
                    #1;
                    check("e_blocked_busy", grant_busy, 1'b0);
                end
                @(negedge aclk) decouple = '0;
            end
        join
        wait_sb_empty("e_drain");

        // Reset during beat 2 of a 4-beat packet, then a fresh packet from port 0.
        @(negedge aclk) drive_beat(3, 'hF3, 0, 4);
        @(negedge aclk);
        #1;
        check("f_grant_port", grant_port, 2'd3);
        check("f_ready", s_axis_tready, 4'b1000);
        @(negedge aclk) drive_beat(3, 'hF3, 1, 4);
        #1 areset = 1'b1;
        #1;
        check("f_rst_tvalid", m_axis_tvalid, 1'b0);
        check("f_rst_tready", s_axis_tready, 4'b0000);
        check("f_rst_busy", grant_busy, 1'b0);
        check("f_rst_port", grant_port, 2'd0);
        @(negedge aclk) src_valid[3] = 1'b0;
        #1;
        check("f_rst_hold_tready", s_axis_tready, 4'b0000);
        @(negedge aclk) areset = 1'b0;
        push_pkt(0, 'hF0, 2);
        fork
            begin
                send_packet(0, 'hF0, 2);
                stop_port(0);
            end
            begin
                @(negedge aclk);
                @(negedge aclk);
                #1;
                check("f_regrant_busy", grant_busy, 1'b1);
                check("f_regrant_port", grant_port, 2'd0);
            end
        join
        wait_sb_empty("final_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
